// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB result stage.
// Load funct3 encodings, source indices and the registered bundle.
package wb_pkg;

  localparam int WB_XLEN = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam int SRC_ALU  = 0;
  localparam int SRC_LOAD = 1;
  localparam int SRC_PC4  = 2;
  localparam int SRC_IMM  = 3;

  typedef struct packed {
    logic [WB_XLEN-1:0] result;
    logic [4:0]         rd;
    logic               reg_write;
  } wb_bundle_t;

endpackage

// File: rtl/load_formatter.sv
// Byte/half extraction and sign/zero extension of load data.
// In: word, funct3, addr_lo. Out: data, misaligned, illegal.
module load_formatter
  import wb_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  output logic [31:0] data,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign shifted  = word >> {addr_lo, 3'b000};
  assign byte_sel = shifted[7:0];
  assign half_sel = addr_lo[1] ? word[31:16]
                               : word[15:0];

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    illegal    = 1'b0;
    unique case (1'b1)
      (funct3 == F3_LB):
        data = {{24{byte_sel[7]}}, byte_sel};
      (funct3 == F3_LBU):
        data = {24'h0, byte_sel};
      (funct3 == F3_LH): begin
        data       = {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      (funct3 == F3_LHU): begin
        data       = {16'h0, half_sel};
        misaligned = addr_lo[0];
      end
      (funct3 == F3_LW):
        misaligned = (addr_lo != 2'b00);
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_result_stage.sv
// MEM/WB stage: N-source select, load formatting, one-entry output reg.
// Ports: in/out valid-ready, src_data/result_src, load ctl, result, err, retired.
module wb_result_stage
  import wb_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NSRC     = 4,
  parameter int LOAD_IDX = 1,
  parameter int CNTW     = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NSRC*XLEN-1:0]    src_data,
  input  logic [$clog2(NSRC)-1:0] result_src,
  input  logic [2:0]              funct3,
  input  logic [1:0]              addr_lo,
  input  logic [4:0]              rd,
  input  logic                    reg_write,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         result,
  output logic [4:0]              rd_out,
  output logic                    we_out,
  output logic                    err,
  output logic [CNTW-1:0]         retired
);

  if (XLEN != 32) begin : g_bad_xlen
    $error("wb_result_stage: XLEN must be 32");
  end
  if (NSRC < 2 || NSRC > 8) begin : g_bad_nsrc
    $error("wb_result_stage: NSRC must be 2..8");
  end

  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] fmt_data;
  logic [XLEN-1:0] sel_data;
  logic            sel_ok;
  logic            is_load;
  logic            mis;
  logic            ill;
  logic            bad;
  logic            accept;
  logic            complete;
  wb_bundle_t      q;

  always_comb begin
    raw = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (int'(result_src) == k)
        raw = src_data[k*XLEN +: XLEN];
    end
  end

  assign sel_ok  = int'(result_src) < NSRC;
  assign is_load = int'(result_src) == LOAD_IDX;

  load_formatter u_fmt (
    .word       (raw),
    .funct3     (funct3),
    .addr_lo    (addr_lo),
    .data       (fmt_data),
    .misaligned (mis),
    .illegal    (ill)
  );

  assign sel_data = is_load ? fmt_data : raw;
  assign bad      = !sel_ok | (is_load & (mis | ill));

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready & !flush;
  assign complete = out_valid & out_ready;

  assign result = q.result;
  assign rd_out = q.rd;
  assign we_out = out_valid & q.reg_write
                & (q.rd != 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      q         <= '0;
      err       <= 1'b0;
      retired   <= '0;
    end else begin
      // a completion coinciding with flush still retires
      if (complete && we_out)
        retired <= retired + CNTW'(1);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        q.result    <= sel_data;
        q.rd        <= rd;
        q.reg_write <= reg_write;
        if (bad)
          err <= 1'b1;
      end else if (complete) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_result_stage.sv
// Randomized + directed bench for wb_result_stage with a spec-level model.
// Second instance with NSRC=3 exercises the out-of-range source select.
module tb_wb_result_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src_w [4];
  logic [127:0] src_data;
  logic [1:0]  result_src;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [4:0]  rd;
  logic        reg_write;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        we_out;
  logic        err;
  logic [31:0] retired;

  logic        in_ready3;
  logic        out_valid3;
  logic [31:0] result3;
  logic [4:0]  rd_out3;
  logic        we_out3;
  logic        err3;
  logic [31:0] retired3;

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_valid;
  logic [31:0] m_res;
  logic [4:0]  m_rd;
  bit          m_rw;
  bit          m_err;
  int unsigned m_ret;

  always #5 clk = ~clk;

  assign src_data = {src_w[3], src_w[2],
                     src_w[1], src_w[0]};

  wb_result_stage #(.NSRC(4)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .src_data   (src_data),
    .result_src (result_src),
    .funct3     (funct3),
    .addr_lo    (addr_lo),
    .rd         (rd),
    .reg_write  (reg_write),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .rd_out     (rd_out),
    .we_out     (we_out),
    .err        (err),
    .retired    (retired)
  );

  wb_result_stage #(.NSRC(3)) u_dut3 (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready3),
    .src_data   (src_data[95:0]),
    .result_src (result_src),
    .funct3     (funct3),
    .addr_lo    (addr_lo),
    .rd         (rd),
    .reg_write  (reg_write),
    .flush      (flush),
    .out_valid  (out_valid3),
    .out_ready  (out_ready),
    .result     (result3),
    .rd_out     (rd_out3),
    .we_out     (we_out3),
    .err        (err3),
    .retired    (retired3)
  );

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  // {error, value} for the main instance (NSRC=4, load source 1)
  function automatic logic [32:0] ref_wb(
    input int rs, input int f3, input int a);
    int unsigned w;
    int unsigned v;
    bit e;
    e = 0;
    if (rs >= 4) return {1'b1, 32'h0};
    w = src_w[rs];
    if (rs != 1) return {1'b0, w};
    case (f3)
      0: begin
        v = (w >> (8 * a)) & 32'hFF;
        if (v >= 128) v = v + 32'hFFFF_FF00;
      end
      4: v = (w >> (8 * a)) & 32'hFF;
      1: begin
        v = (w >> (16 * (a / 2))) & 32'hFFFF;
        if (v >= 32768) v = v + 32'hFFFF_0000;
        e = (a % 2) != 0;
      end
      5: begin
        v = (w >> (16 * (a / 2))) & 32'hFFFF;
        e = (a % 2) != 0;
      end
      2: begin
        v = w;
        e = a != 0;
      end
      default: begin
        v = w;
        e = 1;
      end
    endcase
    return {e, v};
  endfunction

  task automatic model_reset();
    m_valid = 0;
    m_res   = '0;
    m_rd    = '0;
    m_rw    = 0;
    m_err   = 0;
    m_ret   = 0;
  endtask

  task automatic tick();
    logic [32:0] r;
    bit rdy;
    bit acc;
    bit comp;
    #1;
    rdy  = !m_valid || out_ready;
    check("in_ready", in_ready, rdy);
    acc  = in_valid && rdy && !flush;
    comp = m_valid && out_ready;
    r = ref_wb(int'(result_src), int'(funct3),
               int'(addr_lo));
    @(posedge clk);
    #1;
    if (comp && m_rw && m_rd != 0) m_ret++;
    if (flush) m_valid = 0;
    else if (acc) begin
      m_valid = 1;
      m_res   = r[31:0];
      m_rd    = rd;
      m_rw    = reg_write;
      if (r[32]) m_err = 1;
    end else if (comp) m_valid = 0;
    check("out_valid", out_valid, m_valid);
    if (m_valid) begin
      check("result", result, m_res);
      check("rd_out", rd_out, m_rd);
    end
    check("we_out", we_out,
          m_valid && m_rw && m_rd != 0);
    check("err", err, m_err);
    check("retired", retired, m_ret);
  endtask

  task automatic drive(input bit v, input int rs,
                       input int f3, input int a,
                       input int rdv, input bit rw,
                       input bit fl, input bit ordy);
    in_valid   = v;
    result_src = rs[1:0];
    funct3     = f3[2:0];
    addr_lo    = a[1:0];
    rd         = rdv[4:0];
    reg_write  = rw;
    flush      = fl;
    out_ready  = ordy;
    tick();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  int unsigned ret_snap;
  int f3s [7] = '{0, 1, 2, 3, 4, 5, 0};
  int ads [7] = '{0, 1, 2, 3, 3, 2, 0};

  initial begin
    reset_n = 0;
    in_valid = 0; result_src = 0; funct3 = 0;
    addr_lo = 0; rd = 0; reg_write = 0;
    flush = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) src_w[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_rd_out", rd_out, 0);
    check("rst_we_out", we_out, 0);
    check("rst_err", err, 0);
    check("rst_retired", retired, 0);
    check("rst_in_ready", in_ready, 1);
    reset_n = 1;

    // select sweep
    src_w[0] = 32'h8;  src_w[1] = 32'h1;
    src_w[2] = 32'hA;  src_w[3] = 32'hAA;
    drive(1, 0, 2, 0, 5, 1, 0, 1);
    check("sweep0", result, 32'h8);
    check("sweep_we", we_out, 1);
    drive(1, 1, 2, 0, 5, 1, 0, 1);
    check("sweep1", result, 32'h1);
    drive(1, 2, 2, 0, 5, 1, 0, 1);
    check("sweep2", result, 32'hA);
    check("oob_err_pre", err3, 0);
    drive(1, 3, 2, 0, 5, 1, 0, 1);
    check("sweep3", result, 32'hAA);
    check("oob_result", result3, 0);
    check("oob_err", err3, 1);
    idle();
    check("sweep_retired", retired, 4);

    // load extension
    src_w[1] = 32'h80F17F85;
    drive(1, 1, 0, 0, 7, 1, 0, 1);
    check("lb0", result, 32'hFFFFFF85);
    drive(1, 1, 0, 1, 7, 1, 0, 1);
    check("lb1", result, 32'h0000007F);
    drive(1, 1, 0, 2, 7, 1, 0, 1);
    check("lb2", result, 32'hFFFFFFF1);
    drive(1, 1, 0, 3, 7, 1, 0, 1);
    check("lb3", result, 32'hFFFFFF80);
    drive(1, 1, 4, 3, 7, 1, 0, 1);
    check("lbu3", result, 32'h00000080);
    drive(1, 1, 1, 2, 7, 1, 0, 1);
    check("lh2", result, 32'hFFFF80F1);
    drive(1, 1, 5, 0, 7, 1, 0, 1);
    check("lhu0", result, 32'h00007F85);
    idle();
    check("err_pre", err, 0);

    // backpressure: A held, B stalled, then drain
    drive(1, 0, 0, 0, 9, 1, 0, 0);
    src_w[0] = 32'hB0B0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 10, 1, 0, 0);
      check("bp_hold", result, 32'h8);
    end
    drive(1, 0, 0, 0, 10, 1, 0, 1);
    check("bp_next", result, 32'hB0B0);
    idle();
    idle();

    // errors
    drive(1, 1, 1, 1, 3, 1, 0, 1);
    check("mis_err", err, 1);
    for (int i = 0; i < 3; i++)
      drive(1, 0, 2, 0, 4, 1, 0, 1);
    check("err_sticky", err, 1);
    idle();

    // rd=0 and flush
    ret_snap = retired;
    drive(1, 0, 0, 0, 0, 1, 0, 1);
    check("rd0_we", we_out, 0);
    idle();
    check("rd0_ret", retired, ret_snap);
    drive(1, 0, 0, 0, 6, 1, 0, 0);
    drive(1, 0, 0, 0, 6, 1, 1, 1);
    check("flush_valid", out_valid, 0);
    drive(1, 0, 0, 0, 6, 1, 1, 0);
    check("flush_empty", out_valid, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 4; k++) src_w[k] = $urandom;
      drive($urandom_range(0, 3) != 0,
            $urandom_range(0, 3),
            (i % 50 < 40) ? f3s[$urandom_range(0, 6)]
                          : $urandom_range(0, 7),
            (i % 50 < 40) ? ads[$urandom_range(0, 6)]
                          : $urandom_range(0, 3),
            $urandom_range(0, 3) == 0 ? 0
              : $urandom_range(1, 31),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 3) != 0);
    end

    // async reset mid-stream
    drive(1, 1, 1, 1, 8, 1, 0, 1);
    drive(1, 0, 0, 0, 8, 1, 0, 0);
    #2;
    reset_n = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_err", err, 0);
    check("arst_retired", retired, 0);
    check("arst_we", we_out, 0);
    model_reset();
    in_valid = 0;
    out_ready = 0;
    #3;
    reset_n = 1;
    #1;
    check("arst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    drive(1, 2, 0, 0, 12, 1, 0, 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_result_stage.md
# wb_result_stage

Parametrised MEM/WB stage for the pipelined RISC-V core. It replaces the single-cycle three-way result select with an N-source select, load-data byte/half extraction and sign/zero extension, and a registered output with a valid/ready handshake. It also adds flush support, a sticky error flag and a retired-write counter. It sits between the data-memory interface and the register file; its registered output also feeds the forwarding unit.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported, and elaboration fails otherwise.
- `NSRC`, 4: number of result sources, 2..8.
- `LOAD_IDX`, 1: source index whose data passes through load formatting.
- `CNTW`, 32: retired-write counter width.

Ports (name, direction, width, meaning):
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream instruction valid.
- `in_ready` out 1: stage can accept this cycle.
- `src_data` in NSRC*XLEN: source k occupies bits [k*XLEN +: XLEN]. Default map: 0 = ALUResult, 1 = ReadData, 2 = PCPlus4, 3 = ImmExt.
- `result_src` in $clog2(NSRC): source select.
- `funct3` in 3: load type.
- `addr_lo` in 2: ALUResult[1:0] of the load address.
- `rd` in 5: destination register.
- `reg_write` in 1: instruction writes rd.
- `flush` in 1: kill held and incoming instruction.
- `out_valid` out 1: result register holds a valid instruction.
- `out_ready` in 1: register file / hazard unit accepts.
- `result` out XLEN: registered write-back data.
- `rd_out` out 5: registered rd.
- `we_out` out 1: out_valid & reg_write_q & (rd_out != 0).
- `err` out 1: sticky error flag.
- `retired` out CNTW: count of completed register writes.

## Operation
- Combinational select: src = src_data[result_src]. If result_src >= NSRC, src = 0 and an error is raised.
- Load formatting is applied only when result_src == LOAD_IDX:
  - 000 LB: byte addr_lo, sign-extended.
  - 100 LBU: byte addr_lo, zero-extended.
  - 001 LH: half addr_lo[1], sign-extended.
  - 101 LHU: half addr_lo[1], zero-extended.
  - 010 LW: raw word.
  - Other funct3: raw word, and an error is raised.
- Misaligned access raises an error but data is still extracted as above: LH/LHU with addr_lo[0]=1, or LW with addr_lo != 0.
- Accept: in_valid & in_ready. On accept, the formatted value, rd and reg_write are captured.
- in_ready = !out_valid | out_ready. This is a one-entry pipeline register with no bubble on continuous flow.
- Complete: out_valid & out_ready. If we_out=1 at completion, retired increments. The counter wraps at 2^CNTW.
- Simultaneous complete and accept: new data loads and out_valid stays 1.
- Error sources set err only on an accepted instruction. err clears only on reset.
- Flush has priority over everything:
  - Next cycle out_valid=0.
  - The incoming instruction is discarded.
  - An instruction that completes in the same cycle as flush still counts toward retired.
  - Data registers may hold stale values.

## Timing
- Latency is one cycle: an instruction accepted at edge N appears on result/out_valid after edge N.
- Throughput is one per cycle while out_ready=1.
- Reset values (all asynchronous): out_valid=0, result=0, rd_out=0, reg_write_q=0, we_out=0, err=0, retired=0. in_ready=1 after reset.
- Reset asserted mid-operation drops the held instruction immediately, with no completion counted.
- in_ready depends combinationally on out_ready only. It has no path from in_valid.
- result/rd_out are stable while out_valid & !out_ready.

## Structure
- Shared package `wb_pkg`:
  - funct3 load encodings (LB, LH, LW, LBU, LHU).
  - Source-index constants: SRC_ALU=0, SRC_LOAD=1, SRC_PC4=2, SRC_IMM=3.
  - Typedef `wb_bundle_t` (result, rd, reg_write).
- One combinational sub-module, `load_formatter`, with inputs (word, funct3, addr_lo) and outputs (data, misaligned, illegal).

## Test plan
- Select sweep: src_data = {IMM=0x000000AA, PC4=0x0000000A, LOAD=0x00000001, ALU=0x00000008}, result_src 0..3 with reg_write=1, rd=5 -> result 0x8, 0x1, 0xA, 0xAA on consecutive cycles; we_out=1; retired=4.
- Load extension: ReadData=0x80F17F85, LB with addr_lo=0..3 -> 0xFFFFFF85, 0x0000007F, 0xFFFFFFF1, 0xFFFFFF80. LBU with addr_lo=3 -> 0x00000080. LH with addr_lo=2 -> 0xFFFF80F1. LHU with addr_lo=0 -> 0x00007F85.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and result held. Then release -> results drain in order with no loss or duplication.
- Errors: LH with addr_lo=1 -> err=1 and stays 1 across later good instructions. result_src=3 with NSRC=3 -> result=0 and err=1.
- rd=0 / flush: reg_write=1, rd=0 -> we_out=0 and retired unchanged. Flush with in_valid=1 -> next out_valid=0.
- Async reset: reset_n low mid-stream, between clock edges -> out_valid, err and retired read 0 immediately. Reset release -> in_ready=1.
